// File: rtl/file_source_arbiter_if.sv
// file_source_arbiter_if: producer and consumer bus of the arbiter; out_src exists only with FILE_SOURCE_ARBITER_TAG_EN
interface file_source_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_SRC-1:0]            src_ready;
  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_empty;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [NUM_SRC-1:0]            grant;
  logic                          all_empty;
`ifdef FILE_SOURCE_ARBITER_TAG_EN
  logic [$clog2(NUM_SRC)-1:0]    out_src;
  modport master (
    output src_ready, out_valid, out_data, grant, all_empty, out_src,
    input  src_valid, src_empty, src_data, out_ready
  );
  modport slave (
    input  src_ready, out_valid, out_data, grant, all_empty, out_src,
    output src_valid, src_empty, src_data, out_ready
  );
`else
  modport master (
    output src_ready, out_valid, out_data, grant, all_empty,
    input  src_valid, src_empty, src_data, out_ready
  );
  modport slave (
    input  src_ready, out_valid, out_data, grant, all_empty,
    output src_valid, src_empty, src_data, out_ready
  );
`endif
endinterface

// File: rtl/file_source_arbiter.sv
// file_source_arbiter: round-robin sharing of one valid/ready consumer among file-source producers; FILE_SOURCE_ARBITER_TAG_EN adds out_src
module file_source_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST      = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  file_source_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_SRC);
  localparam int BW = $clog2(BURST + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUT} state_t;
  state_t                r_state, w_state;
  logic [IW-1:0]         r_ptr, w_ptr, r_idx, w_idx, w_sel, w_wrap;
  logic [BW-1:0]         r_burst, w_burst;
  logic [NUM_SRC-1:0]    r_grant, w_grant;
  logic                  r_out_valid, w_out_valid, r_all_empty, w_found;
  logic [DATA_WIDTH-1:0] r_out_data, w_out_data;
  logic [DATA_WIDTH-1:0] w_words [NUM_SRC];
`ifdef FILE_SOURCE_ARBITER_TAG_EN
  logic [IW-1:0]         r_src, w_src;
  assign bus.out_src = r_src;
`endif
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_words
    assign w_words[g] = bus.src_data[g*DATA_WIDTH +: DATA_WIDTH];
  end
  assign w_wrap        = (r_idx == IW'(NUM_SRC - 1)) ? '0 : r_idx + 1'b1;
  assign bus.src_ready = (r_state == ISSUE) ? r_grant : '0;
  assign bus.grant     = r_grant;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.all_empty = r_all_empty;
  // First non-empty producer at or after r_ptr, modulo NUM_SRC
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    w_found = 1'b0;
    w_sel   = r_ptr;
    j       = 0;
    jj      = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      j  = int'(r_ptr) + k;
      j  = (j >= NUM_SRC) ? j - NUM_SRC : j;
      jj = IW'(j);
      if (!bus.src_empty[jj]) begin
        w_found = 1'b1;
        w_sel   = jj;
      end
    end
  end
  // Next state and datapath: one request per ISSUE, word captured in CAPTURE, held in OUT
  always_comb begin
    w_state     = r_state;
    w_ptr       = r_ptr;
    w_idx       = r_idx;
    w_burst     = r_burst;
    w_grant     = r_grant;
    w_out_valid = r_out_valid;
    w_out_data  = r_out_data;
`ifdef FILE_SOURCE_ARBITER_TAG_EN
    w_src       = r_src;
`endif
    case (r_state)
      IDLE: if (w_found) begin
        w_idx   = w_sel;
        w_grant = NUM_SRC'(1) << w_sel;
        w_burst = '0;
        w_state = ISSUE;
      end
      ISSUE: w_state = CAPTURE;
      CAPTURE: if (bus.src_valid[r_idx]) begin
        w_out_data  = w_words[r_idx];
        w_out_valid = 1'b1;
`ifdef FILE_SOURCE_ARBITER_TAG_EN
        w_src       = r_idx;
`endif
        w_state     = OUT;
      end else begin
        w_ptr   = w_wrap;
        w_grant = '0;
        w_state = IDLE;
      end
      OUT: if (bus.out_ready) begin
        w_out_valid = 1'b0;
        w_burst     = r_burst + 1'b1;
        if (int'(r_burst) + 1 < BURST && !bus.src_empty[r_idx]) w_state = ISSUE;
        else begin
          w_ptr   = w_wrap;
          w_grant = '0;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  // State register; reset drops any requested or held word
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_burst     <= '0;
      r_grant     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_all_empty <= 1'b0;
`ifdef FILE_SOURCE_ARBITER_TAG_EN
      r_src       <= '0;
`endif
    end else begin
      r_state     <= w_state;
      r_ptr       <= w_ptr;
      r_idx       <= w_idx;
      r_burst     <= w_burst;
      r_grant     <= w_grant;
      r_out_valid <= w_out_valid;
      r_out_data  <= w_out_data;
      r_all_empty <= (r_state == IDLE) && !w_found;
`ifdef FILE_SOURCE_ARBITER_TAG_EN
      r_src       <= w_src;
`endif
    end
  end
endmodule

// File: doc/file_source_arbiter.md
Name: file_source_arbiter

Overview:
- Round-robin scheduler that shares one downstream valid/ready consumer among NUM_SRC testbench file-source producers.
- Each producer answers a one-cycle ready pulse with valid+data exactly one cycle later, and flags empty when exhausted.
- The arbiter pulses ready to one producer at a time, captures the returned word into an output register, and presents it downstream.
- Grants rotate after BURST words or when the granted producer empties; all_empty reports global end of stimulus.

Parameters:
- NUM_SRC, 4, number of producers (2..16).
- DATA_WIDTH, 32, word width.
- BURST, 4, maximum words taken from one producer per grant (>=1).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- src_ready  out  NUM_SRC  one-hot read-request pulse to a producer.
- src_valid  in  NUM_SRC  producer word valid; arrives 1 cycle after its src_ready.
- src_empty  in  NUM_SRC  producer exhausted.
- src_data  in  NUM_SRC*DATA_WIDTH  producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  output word.
- grant  out  NUM_SRC  one-hot current owner; all zero in IDLE.
- all_empty  out  1  all src_empty high, FSM in IDLE, out_valid low.

Behaviour:
- Reset (reset_n low at posedge): state=IDLE, rr_ptr=0, burst_cnt=0.
  - Outputs after reset: src_ready=0, grant=0, out_valid=0, out_data=0, all_empty=0.
- FSM states: IDLE, ISSUE, CAPTURE, OUT.
- IDLE:
  - Select the first i with src_empty[i]==0, searching rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - If found: grant=onehot(i), burst_cnt=0, go ISSUE.
  - If none: stay in IDLE; all_empty=1 (registered, 1-cycle delay).
- ISSUE: src_ready[granted]=1 for exactly this one cycle; go CAPTURE.
- CAPTURE:
  - If src_valid[granted]==1: out_data<=src_data slice, out_valid<=1, go OUT.
  - Otherwise the producer emptied: rr_ptr<=granted+1 (wrap), grant<=0, go IDLE. No output word is produced.
- OUT:
  - Hold out_valid and out_data stable until out_ready==1.
  - On transfer: out_valid<=0, burst_cnt<=burst_cnt+1.
  - If burst_cnt+1<BURST and src_empty[granted]==0: go ISSUE, same grant.
  - Else: rr_ptr<=granted+1 mod NUM_SRC, grant<=0, go IDLE.
- Latency: grant to out_valid is 3 cycles (IDLE→ISSUE→CAPTURE→OUT).
- Throughput: peak is 1 word per 3 cycles within a burst, with out_ready held high.
- src_ready is never asserted to more than one producer, and never outside ISSUE.
- src_valid on a non-granted producer, or outside CAPTURE, is ignored.
- src_empty is sampled only in IDLE and OUT. A producer flagging empty after the ready pulse but still returning valid has its word accepted.
- burst_cnt is $clog2(BURST+1) bits wide and clears on each new grant.
- rr_ptr wraps from NUM_SRC-1 to 0.
- Reset mid-operation:
  - A word already requested (ISSUE or CAPTURE) but not yet presented is discarded.
  - A word held in OUT is dropped without transfer.
  - Outputs take their reset values on the same edge.
- Once all_empty is asserted, it deasserts in the cycle after any src_empty bit falls.

Optional Feature:
- Macro: FILE_SOURCE_ARBITER_TAG_EN.
- Defined:
  - Adds output port out_src, width $clog2(NUM_SRC), giving the index of the producer that supplied out_data.
  - out_src is registered alongside out_data, stable while out_valid=1, and resets to 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Single producer, NUM_SRC=4, BURST=4: only src 2 non-empty with words 0xA0..0xA5, out_ready=1 → out_data sequence A0,A1,A2,A3 then A4,A5. The re-grant to src 2 follows one IDLE cycle, and the final CAPTURE with no valid returns to IDLE. all_empty=1 after src_empty[2] rises.
- Round-robin fairness: all 4 producers hold 8 words (src i words 0xi0..0xi7), BURST=2 → output order 00,01,10,11,20,21,30,31,02,03,..., 32 words total, then all_empty=1.
- Backpressure: out_ready low for 5 cycles during OUT → out_valid and out_data stable for all 5 cycles. No src_ready pulse occurs while stalled; the next word follows the release.
- Empty-on-capture: a producer asserts empty and returns no valid in CAPTURE → no out_valid, grant moves to the next producer, and no word is duplicated or lost.
- Reset mid-burst: reset_n low for 1 cycle while in OUT holding 0x13 → out_valid=0, grant=0, src_ready=0 after that edge. Restart begins the search at src 0.
- Tag macro enabled: repeat the round-robin scenario → out_src equals the high nibble of each word, e.g. 0x21 gives out_src=2.
